// File: rtl/gpio_cfg_writer.sv
// rtl/gpio_cfg_writer.sv - serialises one register write into strobed byte writes on the GPIO config bus
module gpio_cfg_writer #(
  parameter int DATA_W    = 8,
  parameter int N_CHUNKS  = 4,
  parameter int ADDR_W    = 16,
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 2,
  parameter int GAP_CYC   = 2,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       gpio_bus_o,
  output logic              busy,
  output logic              done
);

  localparam int PAD_W = 32 - 1 - DATA_W - ADDR_W;
  localparam int CH_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int PH_W  = 8;
  localparam int STB_BIT = DATA_W + ADDR_W;
  localparam logic [31:0] IDLE_BUS = {{(32-ADDR_W){1'b0}}, IDLE_ADDR};
  localparam logic [CH_W-1:0] TOP_CHUNK = CH_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, GAP} state_t;

  state_t            state;
  logic [CH_W-1:0]   chunk;
  logic [PH_W-1:0]   phase;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  function automatic logic [DATA_W-1:0] sel_byte(input logic [31:0] d, input logic [CH_W-1:0] k);
    logic [31:0] sh;
    sh = d >> (int'(k) * DATA_W);
    return sh[DATA_W-1:0];
  endfunction

  function automatic logic [31:0] bus_word(input logic stb, input logic [DATA_W-1:0] b,
                                           input logic [ADDR_W-1:0] a);
    return {{PAD_W{1'b0}}, stb, b, a};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      chunk      <= '0;
      phase      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      gpio_bus_o <= IDLE_BUS;
      wr_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (wr_valid) begin
            addr_q     <= wr_addr;
            data_q     <= wr_data;
            chunk      <= TOP_CHUNK;
            phase      <= '0;
            state      <= SETUP;
            gpio_bus_o <= bus_word(1'b0, sel_byte(wr_data, TOP_CHUNK), wr_addr);
            wr_ready   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SETUP: begin
          if (phase == PH_W'(SETUP_CYC - 1)) begin
            phase               <= '0;
            state               <= HIGH;
            gpio_bus_o[STB_BIT] <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        HIGH: begin
          if (phase == PH_W'(HIGH_CYC - 1)) begin
            phase               <= '0;
            state               <= GAP;
            gpio_bus_o[STB_BIT] <= 1'b0;
            // done is registered, so it must be raised on entry to the final GAP cycle
            done                <= (chunk == '0) && (GAP_CYC == 1);
          end else begin
            phase <= phase + 1'b1;
          end
        end
        GAP: begin
          if (phase == PH_W'(GAP_CYC - 1)) begin
            phase <= '0;
            done  <= 1'b0;
            if (chunk != '0) begin
              chunk      <= chunk - 1'b1;
              state      <= SETUP;
              gpio_bus_o <= bus_word(1'b0, sel_byte(data_q, chunk - 1'b1), addr_q);
            end else begin
              state      <= IDLE;
              gpio_bus_o <= IDLE_BUS;
              wr_ready   <= 1'b1;
              busy       <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
            done  <= (chunk == '0) && (GAP_CYC >= 2) && (phase == PH_W'(GAP_CYC - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpio_cfg_writer.md
# gpio_cfg_writer

Bus master for the 32-bit GPIO configuration bus that feeds the lock-in's `config_reg` instances. It accepts one parallel register-write request (16-bit address, 32-bit value) over a valid/ready handshake. It serialises the value into byte writes on that bus, most significant byte first, each qualified by a `w_clk` strobe. It sits on the fabric side, so on-chip sequencers can program `user_cntr`, `sinc_in`, `inc_in` and `mul_scalar` without the processor.

## Interface
- `DATA_W`, 8: byte width carried per strobe (bus bits 23:16).
- `N_CHUNKS`, 4: strobes per register write; `N_CHUNKS*DATA_W` must be 32.
- `ADDR_W`, 16: address field width (bus bits 15:0).
- `SETUP_CYC`, 2: cycles address/data are stable with `w_clk` low before it rises; must be ≥1.
- `HIGH_CYC`, 2: cycles `w_clk` is held high; must be ≥1.
- `GAP_CYC`, 2: cycles `w_clk` is low, with data still held, after the fall; must be ≥1.
- `IDLE_ADDR`, 16'hFFFF: address driven when idle; no register may decode it.

- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  request present.
- `wr_ready`  out  1  block can accept; a transfer occurs when `wr_valid` and `wr_ready` are both high at a rising edge.
- `wr_addr`  in  16  target register address.
- `wr_data`  in  32  value to write.
- `gpio_bus_o`  out  32  bus: [15:0] address, [23:16] byte, [24] `w_clk`, [31:25] always 0.
- `busy`  out  1  transaction in progress (the inverse of `wr_ready`).
- `done`  out  1  one-cycle pulse on the cycle the last GAP ends.

## Operation
- The FSM has four states: IDLE, SETUP, HIGH, GAP. A chunk counter runs from `N_CHUNKS-1` down to 0, and a phase counter times each state.
- In IDLE, `wr_ready` is 1. On a transfer, the block latches `wr_addr` and `wr_data` into internal registers and moves to SETUP with chunk = `N_CHUNKS-1`. Inputs are ignored after the accept edge.
- SETUP: bus = {7'b0, 0, byte[chunk], addr}, held for `SETUP_CYC` cycles, then the FSM moves to HIGH.
- HIGH: the same fields with bit 24 = 1, held for `HIGH_CYC` cycles, then the FSM moves to GAP.
- GAP: bit 24 = 0, with address and byte unchanged, for `GAP_CYC` cycles.
  - If chunk > 0, the chunk counter decrements and the FSM returns to SETUP.
  - If chunk = 0, the FSM returns to IDLE and `done` pulses.
- `byte[k]` = `wr_data[k*8+7 : k*8]`. Byte order is 31:24, 23:16, 15:8, 7:0. The receiver shifts left on each `w_clk` rise, so the last byte sent lands in bits 7:0.
- The address field holds the latched address for the whole transaction. Every chunk carries the same address.
- In IDLE the bus is {7'b0, 0, 8'h00, IDLE_ADDR}.
- Back-to-back requests: `wr_ready` rises on the same cycle the bus returns to idle. A request accepted that cycle enters SETUP the next cycle. The bus therefore always shows at least one idle cycle between transactions.
- All outputs are registered; nothing is combinational from the inputs.

## Timing
- Reset value of every output: `gpio_bus_o` = {16'h0000, IDLE_ADDR} (which is 32'h0000FFFF), `wr_ready` = 1, `busy` = 0, `done` = 0.
- Latency: if the accept edge is cycle 0, SETUP for chunk 3 is visible from cycle 1.
- Defaults give 6 cycles per chunk (2 SETUP + 2 HIGH + 2 GAP):
  - first `w_clk` rise visible on cycle 3;
  - rises at cycles 3, 9, 15, 21;
  - `done` pulses on cycle 24;
  - idle bus and `wr_ready` = 1 from cycle 25.
- General transaction length: `N_CHUNKS*(SETUP_CYC+HIGH_CYC+GAP_CYC)` cycles of `busy`.
- Reset mid-transaction: the next cycle shows the idle bus with `w_clk` = 0, no `done` pulse, and `wr_ready` = 1. The target register may be left partially shifted; re-issuing the write is the requester's responsibility.
- `wr_valid` held high continuously produces no extra transfers while busy.
- `wr_valid` may drop before acceptance with no effect.

## Test plan
- Reset, then write addr 16'h0003, data 32'hA1B2C3D4 → bus bytes A1, B2, C3, D4 each with addr 0003. `w_clk` rises at cycles 3, 9, 15, 21. `done` pulses at cycle 24. An attached `config_reg` model at address 3 reads 32'hA1B2C3D4.
- Two back-to-back requests (addr 1, data 1; addr 2, data 32'h00000007) with `wr_valid` held high → the second is accepted on the cycle `wr_ready` returns. There is exactly one idle-bus cycle between them, and both models hold the correct values.
- Assert `rst` for 1 cycle at cycle 10 of a write to addr 0 → next cycle bus = 32'h0000FFFF, `busy` = 0, no `done`. Re-issuing the write completes correctly.
- `wr_valid` toggled while busy, with changing `wr_addr`/`wr_data` → the bus content is unchanged and uses only the latched values.
- `SETUP_CYC`=1, `HIGH_CYC`=1, `GAP_CYC`=1 → a 12-cycle transaction with `w_clk` rises at cycles 2, 5, 8, 11. Bits 31:25 are always 0.
- Idle for 100 cycles with `wr_valid` = 0 → bus constant 32'h0000FFFF, `done` never asserts.
